// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - multi-channel LED pattern generator (static/blink/chase/breathe); breathe mode gated by LED_BREATHE_EN
module led_pattern_ctrl #(
    parameter int                 LED_NUM     = 2,
    parameter int                 CLK_FREQ    = 100_000_000,
    parameter int                 TICK_HZ     = 1000,
    parameter logic [LED_NUM-1:0] RST_PATTERN = LED_NUM'(1),
    parameter int                 RST_PERIOD  = 500
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               cfg_load,
    input  logic [1:0]         mode,
    input  logic [15:0]        period,
    input  logic [LED_NUM-1:0] static_val,
    output logic [LED_NUM-1:0] led,
    output logic               tick_o
);

    localparam int            TICK_DIV   = CLK_FREQ / TICK_HZ;
    localparam int            PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    localparam logic [1:0] MODE_STATIC  = 2'd0;
    localparam logic [1:0] MODE_BLINK   = 2'd1;
    localparam logic [1:0] MODE_CHASE   = 2'd2;
    localparam logic [1:0] MODE_BREATHE = 2'd3;

    logic [PW-1:0]      presc;
    logic               tick;
    logic [1:0]         mode_q;
    logic [15:0]        period_q;
    logic [LED_NUM-1:0] pat_shadow;
    logic [LED_NUM-1:0] pat_reg;
    logic [LED_NUM-1:0] pat_rot;
    logic [15:0]        step_cnt;
    logic [15:0]        step_last;
    logic               step;
    logic               phase;
    logic [LED_NUM-1:0] led_nxt;

    assign tick      = (presc == PRESC_LAST);
    assign tick_o    = tick;
    // a zero period behaves as a period of one tick
    assign step_last = (period_q == 16'd0) ? 16'd0 : period_q - 16'd1;
    assign step      = tick && (step_cnt == step_last);

    // free-running tick prescaler; cfg_load deliberately leaves it running
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // configuration shadows and tick-to-step counter; cfg_load beats a step
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q     <= MODE_STATIC;
            period_q   <= 16'(RST_PERIOD);
            pat_shadow <= RST_PATTERN;
            step_cnt   <= '0;
        end else if (cfg_load) begin
            mode_q     <= mode;
            period_q   <= period;
            pat_shadow <= static_val;
            step_cnt   <= '0;
        end else if (step) begin
            step_cnt   <= '0;
        end else if (tick) begin
            step_cnt   <= step_cnt + 16'd1;
        end
    end

    // circular left rotate; a single LED simply holds its value
    generate
        if (LED_NUM == 1) begin : g_rot_one
            assign pat_rot = pat_reg;
        end else begin : g_rot_many
            assign pat_rot = {pat_reg[LED_NUM-2:0], pat_reg[LED_NUM-1]};
        end
    endgenerate

    // working pattern: reloaded on cfg_load, rotated on each chase step
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pat_reg <= RST_PATTERN;
        end else if (cfg_load) begin
            pat_reg <= static_val;
        end else if (step && (mode_q == MODE_CHASE)) begin
            pat_reg <= pat_rot;
        end
    end

    // blink phase toggles once per step
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            phase <= 1'b0;
        end else if (cfg_load) begin
            phase <= 1'b0;
        end else if (step && (mode_q == MODE_BLINK)) begin
            phase <= ~phase;
        end
    end

`ifdef LED_BREATHE_EN
    logic [7:0] pwm_cnt;
    logic [7:0] duty;
    logic       dir_down;

    // free-running 8-bit PWM carrier
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    // triangle duty ramp; direction flips on the step that reaches an end
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            duty     <= '0;
            dir_down <= 1'b0;
        end else if (cfg_load) begin
            duty     <= '0;
            dir_down <= 1'b0;
        end else if (step && (mode_q == MODE_BREATHE)) begin
            if (!dir_down) begin
                duty <= duty + 8'd1;
                if (duty == 8'd254) begin
                    dir_down <= 1'b1;
                end
            end else begin
                duty <= duty - 8'd1;
                if (duty == 8'd1) begin
                    dir_down <= 1'b0;
                end
            end
        end
    end
`endif

    // next LED value: a fresh config is shown immediately, otherwise follow state
    always_comb begin
        led_nxt = pat_shadow;
        if (cfg_load) begin
            led_nxt = static_val;
`ifdef LED_BREATHE_EN
            if (mode == MODE_BREATHE) begin
                led_nxt = '0;
            end
`endif
        end else begin
            case (mode_q)
                MODE_BLINK:   led_nxt = phase ? ~pat_shadow : pat_shadow;
                MODE_CHASE:   led_nxt = pat_reg;
`ifdef LED_BREATHE_EN
                MODE_BREATHE: led_nxt = (pwm_cnt < duty) ? pat_shadow : '0;
`endif
                default:      led_nxt = pat_shadow;
            endcase
        end
    end

    // registered LED drive
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            led <= '0;
        end else begin
            led <= led_nxt;
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb/tb_led_pattern_ctrl.sv - randomized self-checking bench for led_pattern_ctrl against a tick/step-count model
module tb_led_pattern_ctrl;

    localparam int CLK_FREQ = 1000;
    localparam int TICK_HZ  = 100;
    localparam int TDIV     = CLK_FREQ / TICK_HZ;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        cfg_load  = 1'b0;
    logic [1:0]  mode      = 2'd0;
    logic [15:0] period    = 16'd0;
    logic [3:0]  sval      = 4'd0;
    logic [1:0]  led2;
    logic [3:0]  led4;
    logic        tick2;
    logic        tick4;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    led_pattern_ctrl #(
        .LED_NUM(2), .CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ),
        .RST_PATTERN(2'b01), .RST_PERIOD(500)
    ) dut2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg_load(cfg_load),
        .mode(mode), .period(period), .static_val(sval[1:0]),
        .led(led2), .tick_o(tick2)
    );

    led_pattern_ctrl #(
        .LED_NUM(4), .CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ),
        .RST_PATTERN(4'b0001), .RST_PERIOD(500)
    ) dut4 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg_load(cfg_load),
        .mode(mode), .period(period), .static_val(sval),
        .led(led4), .tick_o(tick4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // pattern shown after `steps` completed steps since the last config
    function automatic logic [31:0] pat_fn(input int w, input int md, input logic [31:0] pat,
                                           input int steps, input int pwm);
        logic [31:0] mask;
        int r;
        int d;
        int duty;
        mask = (32'd1 << w) - 32'd1;
        pat  = pat & mask;
        case (md)
            1: return (steps % 2 == 1) ? (~pat & mask) : pat;
            2: begin
                r = steps % w;
                return ((pat << r) | (pat >> (w - r))) & mask;
            end
            3: begin
`ifdef LED_BREATHE_EN
                d    = steps % 510;
                duty = (d <= 255) ? d : 510 - d;
                return (pwm < duty) ? pat : 32'd0;
`else
                d    = 0;
                duty = d;
                return pat;
`endif
            end
            default: return pat;
        endcase
    endfunction

    // model state: edges since reset, ticks since last config
    int          m_k     = 0;
    int          m_mode  = 0;
    int          m_p     = 500;
    int          m_ticks = 0;
    logic [31:0] m_pat2  = 32'd1;
    logic [31:0] m_pat4  = 32'd1;
    logic [31:0] exp2    = 32'd0;
    logic [31:0] exp4    = 32'd0;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_k = 0; m_mode = 0; m_p = 500; m_ticks = 0;
            m_pat2 = 32'd1; m_pat4 = 32'd1; exp2 = 32'd0; exp4 = 32'd0;
        end else begin
            if (cfg_load) begin
                exp2    = pat_fn(2, int'(mode), 32'(sval[1:0]), 0, 0);
                exp4    = pat_fn(4, int'(mode), 32'(sval), 0, 0);
                m_mode  = int'(mode);
                m_p     = (period == 16'd0) ? 1 : int'(period);
                m_pat2  = 32'(sval[1:0]);
                m_pat4  = 32'(sval);
                m_ticks = 0;
            end else begin
                exp2 = pat_fn(2, m_mode, m_pat2, m_ticks / m_p, m_k % 256);
                exp4 = pat_fn(4, m_mode, m_pat4, m_ticks / m_p, m_k % 256);
                if (m_k % TDIV == TDIV - 1) m_ticks++;
            end
            m_k++;
        end
    end

    // per-cycle comparison against the model
    always @(negedge sys_clk) begin
        check("led2", 32'(led2), exp2);
        check("led4", 32'(led4), exp4);
        check("tick2", 32'(tick2), 32'((m_k % TDIV) == TDIV - 1));
        check("tick4", 32'(tick4), 32'((m_k % TDIV) == TDIV - 1));
    end

    task automatic wait_tick4();
        bit seen;
        seen = 1'b0;
        for (int j = 0; j < 25 && !seen; j++) begin
            @(negedge sys_clk);
            if (tick4) seen = 1'b1;
        end
        check("tick_seen", 32'(seen), 32'd1);
    endtask

    task automatic pulse_cfg(input logic [1:0] md, input logic [15:0] per, input logic [3:0] sv);
        mode = md; period = per; sval = sv; cfg_load = 1'b1;
        @(negedge sys_clk);
        cfg_load = 1'b0;
    endtask

    logic [3:0] chase_exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        repeat (3) @(negedge sys_clk);
        check("rst_led2", 32'(led2), 32'd0);
        check("rst_tick", 32'(tick2), 32'd0);
        sys_rst_n = 1'b1;

        // reset defaults: static 01, tick at cycles 9, 19
        for (int c = 1; c <= 20; c++) begin
            @(negedge sys_clk);
            check("boot_led2", 32'(led2), 32'd1);
            check("boot_tick", 32'(tick2), 32'(c % 10 == 9));
        end

        // blink, period 3, config in cycle 20
        pulse_cfg(2'd1, 16'd3, 4'b0101);
        check("blink_first", 32'(led2), 32'b01);
        repeat (29) @(negedge sys_clk);
        check("blink_c50", 32'(led2), 32'b01);
        @(negedge sys_clk);
        check("blink_c51", 32'(led2), 32'b10);
        check("blink4_c51", 32'(led4), 32'b1010);
        repeat (30) @(negedge sys_clk);
        check("blink_c81", 32'(led2), 32'b01);

        // randomized configs, with input noise between pulses
        for (int i = 0; i < 40; i++) begin
            pulse_cfg(2'($urandom_range(0, 3)), 16'($urandom_range(0, 4)), 4'($urandom));
            mode = 2'($urandom); period = 16'($urandom); sval = 4'($urandom);
            repeat ($urandom_range(3, 150)) @(negedge sys_clk);
        end

        // chase on 4 LEDs, config aligned to a tick
        wait_tick4();
        pulse_cfg(2'd2, 16'd1, 4'b0001);
        check("chase_first", 32'(led4), 32'b0001);
        for (int i = 0; i < 4; i++) begin
            wait_tick4();
            repeat (2) @(negedge sys_clk);
            check("chase_step", 32'(led4), 32'(chase_exp[i]));
        end

        // asynchronous reset mid-chase
        repeat (4) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        check("arst_led4", 32'(led4), 32'd0);
        check("arst_led2", 32'(led2), 32'd0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("rel_led4", 32'(led4), 32'b0001);
        check("rel_led2", 32'(led2), 32'b01);
        repeat (40) @(negedge sys_clk);
        check("rel_static4", 32'(led4), 32'b0001);

        // breathe (or static fallback)
        pulse_cfg(2'd3, 16'd1, 4'b1111);
`ifdef LED_BREATHE_EN
        check("breathe_off", 32'(led2), 32'd0);
        repeat (5200) @(negedge sys_clk);
`else
        for (int c = 0; c < 50; c++) begin
            check("breathe_static", 32'(led2), 32'b11);
            @(negedge sys_clk);
        end
`endif

        // blink with period 0 behaves as period 1
        pulse_cfg(2'd1, 16'd0, 4'b0001);
        repeat (60) @(negedge sys_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
